// File: rtl/rr_bus_arbiter_if.sv
// rtl/rr_bus_arbiter_if.sv - request/grant bundle between bus sources and the round-robin arbiter
interface rr_bus_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_sel;
   logic       gnt_valid;
   logic       revoked;

   modport master (
      input  req,
      output gnt,
      output gnt_sel,
      output gnt_valid,
      output revoked
   );

   modport slave (
      output req,
      input  gnt,
      input  gnt_sel,
      input  gnt_valid,
      input  revoked
   );
endinterface

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - four-source round-robin tristate arbiter with all-off turnaround gap
// Optional hold-timeout preemption enabled by defining RR_ARB_TIMEOUT_EN.
module rr_bus_arbiter #(
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_bus_arbiter_if.master bus
);

   if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("rr_bus_arbiter: TURN_CYCLES or MAX_HOLD out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

   localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

   state_t     state_q;
   logic [1:0] last_q;
   logic [3:0] turn_cnt_q;
   logic [3:0] gnt_q;
   logic [1:0] sel_q;
   logic       valid_q;
   logic       revoked_q;

   logic [1:0] win_idx;
   logic [1:0] cand;
   logic       win_found;
   logic       preempt;
   logic       arb_now;

   // Search starts just after the last owner, so the last owner itself comes last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign arb_now = (state_q == S_IDLE) || (state_q == S_TURN && turn_cnt_q == 4'd0);

`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q;
   // gnt_q is the owner's one-hot during GRANT, so this masks out the owner's own request.
   assign preempt = (hold_q == HOLD_LIM) && |(bus.req & ~gnt_q);
`else
   assign preempt = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_q     <= 2'd3;
         turn_cnt_q <= 4'd0;
         gnt_q      <= 4'd0;
         sel_q      <= 2'd0;
         valid_q    <= 1'b0;
         revoked_q  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
         hold_q     <= 8'd0;
`endif
      end else begin
         revoked_q <= 1'b0;
         case (state_q)
            S_GRANT: begin
               if (!bus.req[sel_q] || preempt) begin
                  state_q    <= S_TURN;
                  turn_cnt_q <= TURN_LOAD;
                  gnt_q      <= 4'd0;
                  sel_q      <= 2'd0;
                  valid_q    <= 1'b0;
                  revoked_q  <= bus.req[sel_q];
               end
`ifdef RR_ARB_TIMEOUT_EN
               else if (hold_q != HOLD_LIM) begin
                  hold_q <= hold_q + 8'd1;
               end
`endif
            end
            default: begin
               if (arb_now) begin
                  if (win_found) begin
                     state_q <= S_GRANT;
                     last_q  <= win_idx;
                     gnt_q   <= 4'b0001 << win_idx;
                     sel_q   <= win_idx;
                     valid_q <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                     hold_q  <= 8'd0;
`endif
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  turn_cnt_q <= turn_cnt_q - 4'd1;
               end
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_sel   = sel_q;
   assign bus.gnt_valid = valid_q;
   assign bus.revoked   = revoked_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - self-checking bench for rr_bus_arbiter against a behavioural model
module tb_rr_bus_arbiter;
   localparam int TURN = 3;
   localparam int HOLD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   rr_bus_arbiter_if bus();

   rr_bus_arbiter #(.TURN_CYCLES(TURN), .MAX_HOLD(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: who owns the line, how many all-off cycles remain, who owned it last.
   int m_owner = -1;
   int m_gap   = 0;
   int m_last  = 3;
   int m_held  = 0;
   bit m_rev   = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_pick();
      m_gap = 0;
      for (int i = 1; i <= 4; i++) begin
         if (m_owner < 0 && bus.req[(m_last + i) % 4]) begin
            m_owner = (m_last + i) % 4;
            m_last  = m_owner;
            m_held  = 1;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_owner = -1; m_gap = 0; m_last = 3; m_held = 0; m_rev = 1'b0;
         end else begin
            m_rev = 1'b0;
            if (m_owner >= 0) begin
               if (!bus.req[m_owner]) begin
                  m_owner = -1; m_gap = TURN;
               end
`ifdef RR_ARB_TIMEOUT_EN
               else if (m_held >= HOLD && (bus.req & ~(4'b0001 << m_owner)) != 4'd0) begin
                  m_owner = -1; m_gap = TURN; m_rev = 1'b1;
               end
`endif
               else m_held++;
            end else if (m_gap > 1) begin
               m_gap--;
            end else begin
               model_pick();
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("gnt",       {4'd0, bus.gnt},   (m_owner >= 0) ? 8'(4'b0001 << m_owner) : 8'd0);
            check("gnt_sel",   {6'd0, bus.gnt_sel}, (m_owner >= 0) ? 8'(m_owner) : 8'd0);
            check("gnt_valid", {7'd0, bus.gnt_valid}, {7'd0, m_owner >= 0});
            check("revoked",   {7'd0, bus.revoked}, {7'd0, m_rev});
         end
      end
   end

   task automatic wait_grant(output int sel, inout int gap);
      sel = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.gnt_valid) begin
            sel = int'(bus.gnt_sel);
            return;
         end
         gap++;
      end
      check("grant_wait_expired", 8'd0, 8'd1);
   endtask

   task automatic do_reset();
      bus.req = 4'd0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
   endtask

   initial begin
      int s;
      int gap;
      int cyc;
      bus.req = 4'd0;
      do_reset();
      check("rst_gnt",     {4'd0, bus.gnt}, 8'd0);
      check("rst_valid",   {7'd0, bus.gnt_valid}, 8'd0);
      check("rst_sel",     {6'd0, bus.gnt_sel}, 8'd0);
      check("rst_revoked", {7'd0, bus.revoked}, 8'd0);

      bus.req = 4'b0100;
      @(negedge clk);
      check("single_gnt",   {4'd0, bus.gnt}, 8'b0100);
      check("single_sel",   {6'd0, bus.gnt_sel}, 8'd2);
      check("single_valid", {7'd0, bus.gnt_valid}, 8'd1);
      bus.req = 4'd0;
      repeat (5) @(negedge clk);

      bus.req = 4'b0010;
      @(negedge clk);
      check("turn_owner1", {4'd0, bus.gnt}, 8'b0010);
      bus.req = 4'b0110;
      repeat (2) @(negedge clk);
      check("turn_hold_ignores_other", {4'd0, bus.gnt}, 8'b0010);
      bus.req = 4'b0100;
      gap = 0;
      wait_grant(s, gap);
      check("turn_gap", 8'(gap), 8'(TURN));
      check("turn_next_gnt", {4'd0, bus.gnt}, 8'b0100);

      bus.req = 4'b1000;
      gap = 0;
      wait_grant(s, gap);
      check("areset_pre_gnt", {4'd0, bus.gnt}, 8'b1000);
      #2 rst_n = 1'b0;
      #1;
      check("areset_gnt",   {4'd0, bus.gnt}, 8'd0);
      check("areset_valid", {7'd0, bus.gnt_valid}, 8'd0);
      #1 rst_n = 1'b1;
      bus.req = 4'b1001;
      @(negedge clk);
      check("areset_src0_first", {4'd0, bus.gnt}, 8'b0001);

      do_reset();
      bus.req = 4'b1111;
      gap = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(s, gap);
         check("rr_order", 8'(s), 8'(k % 4));
         if (k > 0) check("rr_gap", 8'(gap), 8'(TURN));
         repeat (2) @(negedge clk);
         if (s >= 0) bus.req[s[1:0]] = 1'b0;
         @(negedge clk);
         bus.req = 4'b1111;
         gap = 1;
      end
      bus.req = 4'd0;
      repeat (5) @(negedge clk);

`ifdef RR_ARB_TIMEOUT_EN
      do_reset();
      bus.req = 4'b0011;
      gap = 0;
      wait_grant(s, gap);
      check("to_first_owner", 8'(s), 8'd0);
      cyc = 1;
      for (int c = 0; c < 40 && bus.gnt == 4'b0001; c++) begin
         @(negedge clk);
         if (bus.gnt == 4'b0001) cyc++;
      end
      check("to_hold_cycles", 8'(cyc), 8'(HOLD));
      check("to_revoked", {7'd0, bus.revoked}, 8'd1);
      gap = 1;
      wait_grant(s, gap);
      check("to_gap", 8'(gap), 8'(TURN));
      check("to_next_gnt", {4'd0, bus.gnt}, 8'b0010);

      do_reset();
      bus.req = 4'b0001;
      repeat (20) @(negedge clk);
      check("to_solo_gnt",     {4'd0, bus.gnt}, 8'b0001);
      check("to_solo_revoked", {7'd0, bus.revoked}, 8'd0);
`else
      cyc = 0;
`endif

      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] flip;
         @(negedge clk);
         for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
         bus.req = bus.req ^ flip;
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Four-requester round-robin arbiter that owns the shared tristate data line. It drives the line's one-hot buffer enables, plus an encoded select, so exactly one source ever drives the line. It inserts a guaranteed all-off turnaround gap between owners so no two buffers overlap. Sits between the four bus sources and the 2:4 enable decode / tristate stage.

## Interface
- TURN_CYCLES, 1, idle cycles (all enables off) between consecutive grants; legal range 1..15
- MAX_HOLD, 16, max consecutive grant cycles before preemption (used only with RR_ARB_TIMEOUT_EN); legal range 2..255
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  level requests; bit i = source i wants the line
- gnt  output  4  registered one-hot (or zero) tristate enable; bit i enables source i's buffer
- gnt_sel  output  2  encoded index of current owner; valid only when gnt_valid=1
- gnt_valid  output  1  OR of gnt
- revoked  output  1  one-cycle pulse: grant was preempted by timeout

## Operation
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req != 0, pick a winner and go to GRANT; gnt becomes the winner's one-hot.
  - Otherwise stay in IDLE with gnt=0.
- Arbitration is round-robin:
  - Search starts at (last_owner+1) mod 4 and proceeds upward with wrap.
  - last_owner updates on every grant.
  - Reset sets last_owner=3, so source 0 has top priority after reset.
- GRANT:
  - Hold gnt while req[owner]=1; other requests are ignored.
  - On req[owner]=0, go to TURN; gnt=0 from the next edge.
- TURN:
  - Stay in TURN for exactly TURN_CYCLES cycles with gnt=0.
  - On the final TURN cycle, arbitrate as in IDLE: if any req, go directly to GRANT; else go to IDLE.
- gnt is never non-zero in two different bits, and never changes owner without a zero gap.
- Requests dropped before being granted are simply lost; there is no queueing.
- Invariants: gnt_valid == |gnt; gnt_sel == encode(gnt) while gnt_valid=1, and 0 otherwise.

## Timing
- Reset values: gnt=0, gnt_sel=0, gnt_valid=0, revoked=0, state=IDLE, last_owner=3, counters=0.
- Reset is asynchronous: asserting rst_n mid-grant clears gnt immediately, without waiting for an edge.
- Grant latency from IDLE: req sampled high at edge k -> gnt valid after edge k.
- Release: req[owner] sampled low at edge n -> gnt=0 after edge n.
- Next grant: earliest after edge n+TURN_CYCLES; the line is undriven for exactly TURN_CYCLES cycles.
- Simultaneous requests at the same edge are resolved by round-robin order only.
- A new req arriving during TURN is eligible at the final TURN edge.
- Owner dropping and re-raising req within TURN:
  - It competes normally.
  - Its own priority is lowest, since last_owner equals its index.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - The owner is preempted when the counter reaches MAX_HOLD-1 and any other req bit is high.
  - On preemption: go to TURN, gnt=0 after that edge, and revoked=1 for that same cycle.
  - With no competing request, the counter saturates and the owner keeps the grant.
- RR_ARB_TIMEOUT_EN undefined:
  - There is no hold counter; the owner holds until it drops req.
  - revoked is tied to 0 and MAX_HOLD is ignored.

## Test plan
- Reset/single request: rst_n low then high, req=4'b0100 -> gnt=4'b0100, gnt_sel=2, gnt_valid=1 one edge later.
- Round-robin fairness: req=4'b1111 held, each owner drops req for 1 cycle after 3 grant cycles -> grant order 0,1,2,3,0 with TURN_CYCLES zero cycles between each.
- Turnaround: TURN_CYCLES=3, owner 1 releases while req[2]=1 -> gnt=0 for exactly 3 cycles, then gnt=4'b0100; no cycle with 2 bits set.
- Async reset mid-grant: gnt=4'b1000, pull rst_n low between edges -> gnt=0 and gnt_valid=0 immediately; after release, source 0 wins first.
- Timeout, with RR_ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0011 held -> owner 0 gets 4 grant cycles, revoked pulses once, then a TURN gap, then gnt=4'b0010.
- Timeout, no competitor: req=4'b0001 held for 20 cycles with the macro defined -> gnt stays 4'b0001 and revoked stays 0.
